// File: rtl/ripple_add_pkg.sv
// ripple_add_pkg: shared types and helpers for the ripple-add scheduler.
//   state_e - scheduler FSM states (idle / slice-add / response)
//   id_w    - index width for n items, never less than one bit
package ripple_add_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StAdd,
        StDone
    } state_e;

    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ripple_slice.sv
// ripple_slice: purely combinational SLICE-bit ripple-carry adder built from full-adder cells.
// Ports:
//   a, b - slice operands
//   cin  - carry into bit 0
//   sum  - a + b + cin, low SLICE bits
//   cout - carry out of the slice MSB
module ripple_slice #(
    parameter int SLICE = 4
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             cin,
    output logic [SLICE-1:0] sum,
    output logic             cout
);

    logic [SLICE:0] carry;

    assign carry[0] = cin;

    for (genvar i = 0; i < SLICE; i++) begin : g_fa
        assign sum[i]       = a[i] ^ b[i] ^ carry[i];
        assign carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end

    assign cout = carry[SLICE];

endmodule

// File: rtl/ripple_add_sched.sv
// ripple_add_sched: round-robin scheduler sharing one SLICE-bit ripple adder among N_REQ
// requesters. A granted WIDTH-bit add runs over WIDTH/SLICE cycles, LSB slice first, with the
// carry registered between slices.
// Ports:
//   clk, rst_n           - clock, asynchronous active-low reset
//   req_valid/req_ready  - per-requester handshake; req_ready is one-hot or zero
//   req_a, req_b         - packed operands, requester i at [i*WIDTH +: WIDTH]
//   req_cin              - per-requester carry-in
//   rsp_valid/rsp_ready  - response handshake
//   rsp_id               - index of the requester owning the result
//   rsp_sum, rsp_cout    - A+B+cin mod 2^WIDTH and carry out of the MSB
module ripple_add_sched
    import ripple_add_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req_valid,
    output logic [N_REQ-1:0]         req_ready,
    input  logic [N_REQ*WIDTH-1:0]   req_a,
    input  logic [N_REQ*WIDTH-1:0]   req_b,
    input  logic [N_REQ-1:0]         req_cin,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [id_w(N_REQ)-1:0]   rsp_id,
    output logic [WIDTH-1:0]         rsp_sum,
    output logic                     rsp_cout
);

    localparam int NS    = WIDTH / SLICE;
    localparam int ID_W  = id_w(N_REQ);
    localparam int CNT_W = id_w(NS);

    if ((WIDTH % SLICE) != 0) begin : g_bad_slice
        $error("ripple_add_sched: WIDTH must be a multiple of SLICE");
    end
    if (N_REQ < 2) begin : g_bad_nreq
        $error("ripple_add_sched: N_REQ must be at least 2");
    end

    state_e             state_q, state_d;
    logic [ID_W-1:0]    rr_q, rr_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               carry_q, carry_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   sum_q, sum_d;

    logic               grant_found;
    logic [ID_W-1:0]    grant_id;
    logic [ID_W:0]      cand;

    logic [SLICE-1:0]   slice_a, slice_b, slice_sum;
    logic               slice_cout;

    // Round-robin search: first valid requester at or after rr_q, wrapping modulo N_REQ.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        cand        = '0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = {1'b0, rr_q} + (ID_W + 1)'(i);
            if (cand >= (ID_W + 1)'(N_REQ)) begin
                cand = cand - (ID_W + 1)'(N_REQ);
            end
            if (!grant_found && req_valid[cand[ID_W-1:0]]) begin
                grant_found = 1'b1;
                grant_id    = cand[ID_W-1:0];
            end
        end
    end

    // Gated by rst_n so no requester sees an accept while reset is held.
    always_comb begin
        req_ready = '0;
        if (rst_n && state_q == StIdle && grant_found) begin
            req_ready[grant_id] = 1'b1;
        end
    end

    assign slice_a = a_q[cnt_q*SLICE +: SLICE];
    assign slice_b = b_q[cnt_q*SLICE +: SLICE];

    ripple_slice #(
        .SLICE (SLICE)
    ) u_slice (
        .a    (slice_a),
        .b    (slice_b),
        .cin  (carry_q),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        id_d    = id_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        unique case (state_q)
            StIdle: begin
                if (grant_found) begin
                    a_d     = req_a[grant_id*WIDTH +: WIDTH];
                    b_d     = req_b[grant_id*WIDTH +: WIDTH];
                    carry_d = req_cin[grant_id];
                    id_d    = grant_id;
                    cnt_d   = '0;
                    rr_d    = (grant_id == ID_W'(N_REQ - 1)) ? '0 : grant_id + 1'b1;
                    state_d = StAdd;
                end
            end
            StAdd: begin
                sum_d[cnt_q*SLICE +: SLICE] = slice_sum;
                carry_d = slice_cout;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(NS - 1)) begin
                    cnt_d   = '0;
                    state_d = StDone;
                end
            end
            StDone: begin
                // Return to idle only; the next accept waits for a cycle in StIdle.
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            rr_q    <= '0;
            id_q    <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            id_q    <= id_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
        end
    end

    assign rsp_valid = (state_q == StDone);
    assign rsp_id    = id_q;
    assign rsp_sum   = sum_q;
    assign rsp_cout  = carry_q;

endmodule
